// File: rtl/edit_pkg.sv
// Shared types and constants for the seven-segment editor control path.
package edit_pkg;

    typedef enum logic {
        ST_VIEW = 1'b0,
        ST_EDIT = 1'b1
    } state_e;

    localparam int unsigned KEY_MODE  = 0;
    localparam int unsigned KEY_LEFT  = 1;
    localparam int unsigned KEY_RIGHT = 2;
    localparam int unsigned KEY_UP    = 3;
    localparam int unsigned KEY_DOWN  = 4;
    localparam int unsigned KEY_W     = 5;

    localparam int unsigned CURSOR_W  = 4;

    typedef struct packed {
        logic l_mov;
        logic r_mov;
        logic add;
        logic sub;
    } cmd_t;

    // Lowest set bit wins, which matches mode > left > right > up > down.
    function automatic logic [KEY_W-1:0] key_select(input logic [KEY_W-1:0] kp);
        return kp & (~kp + KEY_W'(1));
    endfunction

endpackage

// File: rtl/edit_tick_counter.sv
// Modulo-N tick counter with synchronous clear, count enable and terminal-count flag.
module edit_tick_counter #(
    parameter  int unsigned N = 4,
    localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == W'(N - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/edit_sequencer.sv
// Editor control FSM: key pulses -> cursor/digit commands, blink and idle timeout.
// Optional AUTO_REPEAT_EN: held up/down keys re-issue add/sub after a delay.
module edit_sequencer
    import edit_pkg::*;
#(
    parameter int unsigned DIGITS         = 8,
    parameter int unsigned BLINK_DIV      = 16_666_666,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000,
    parameter int unsigned REPEAT_DELAY   = 50_000_000,
    parameter int unsigned REPEAT_RATE    = 10_000_000
) (
    input  logic                clk100mhz,
    input  logic                clr,
    input  logic [KEY_W-1:0]    key_pulse,
    input  logic [KEY_W-1:0]    key_level,
    output logic                state,
    output logic                shine,
    output logic [CURSOR_W-1:0] who,
    output logic                l_mov,
    output logic                r_mov,
    output logic                add,
    output logic                sub
);

    state_e              state_q, state_d;
    logic [CURSOR_W-1:0] who_q, who_d;
    logic                shine_q, shine_d;
    cmd_t                cmd_q, cmd_d;

    logic [KEY_W-1:0]    sel;
    logic                any_key;
    logic                blink_clr, blink_en, blink_tc;
    logic                to_clr, to_en, to_tc;
    logic                rpt_fire, rpt_up;

    assign sel     = key_select(key_pulse);
    assign any_key = |key_pulse;

    edit_tick_counter #(.N(BLINK_DIV)) u_blink (
        .clk_i (clk100mhz),
        .rst_i (clr),
        .clr_i (blink_clr),
        .en_i  (blink_en),
        .tc_o  (blink_tc)
    );

    edit_tick_counter #(.N(TIMEOUT_CYCLES)) u_timeout (
        .clk_i (clk100mhz),
        .rst_i (clr),
        .clr_i (to_clr),
        .en_i  (to_en),
        .tc_o  (to_tc)
    );

`ifdef AUTO_REPEAT_EN
    logic rpt_act_q, rpt_act_d;
    logic rpt_key_up_q, rpt_key_up_d;
    logic rpt_rate_q, rpt_rate_d;
    logic dly_clr, dly_en, dly_tc;
    logic rate_clr, rate_en, rate_tc;
    logic held;

    edit_tick_counter #(.N(REPEAT_DELAY)) u_rpt_delay (
        .clk_i (clk100mhz),
        .rst_i (clr),
        .clr_i (dly_clr),
        .en_i  (dly_en),
        .tc_o  (dly_tc)
    );

    edit_tick_counter #(.N(REPEAT_RATE)) u_rpt_rate (
        .clk_i (clk100mhz),
        .rst_i (clr),
        .clr_i (rate_clr),
        .en_i  (rate_en),
        .tc_o  (rate_tc)
    );

    assign held   = rpt_key_up_q ? key_level[KEY_UP] : key_level[KEY_DOWN];
    assign rpt_up = key_level[KEY_UP];

    // Repeat runs in two phases: initial delay, then the steady rate.
    always_comb begin
        rpt_act_d    = rpt_act_q;
        rpt_key_up_d = rpt_key_up_q;
        rpt_rate_d   = rpt_rate_q;
        dly_clr      = 1'b0;
        dly_en       = 1'b0;
        rate_clr     = 1'b0;
        rate_en      = 1'b0;
        rpt_fire     = 1'b0;
        if (state_q != ST_EDIT) begin
            rpt_act_d = 1'b0;
        end else if (any_key) begin
            rpt_act_d    = sel[KEY_UP] | sel[KEY_DOWN];
            rpt_key_up_d = sel[KEY_UP];
            rpt_rate_d   = 1'b0;
            dly_clr      = 1'b1;
            rate_clr     = 1'b1;
        end else if (rpt_act_q && held) begin
            if (!rpt_rate_q) begin
                dly_en = 1'b1;
                if (dly_tc) begin
                    rpt_fire   = 1'b1;
                    rpt_rate_d = 1'b1;
                    rate_clr   = 1'b1;
                end
            end else begin
                rate_en  = 1'b1;
                rpt_fire = rate_tc;
            end
        end else begin
            rpt_act_d = 1'b0;
        end
    end

    always_ff @(posedge clk100mhz or posedge clr) begin
        if (clr) begin
            rpt_act_q    <= 1'b0;
            rpt_key_up_q <= 1'b0;
            rpt_rate_q   <= 1'b0;
        end else begin
            rpt_act_q    <= rpt_act_d;
            rpt_key_up_q <= rpt_key_up_d;
            rpt_rate_q   <= rpt_rate_d;
        end
    end
`else
    logic unused_key_level;

    assign unused_key_level = ^key_level;
    assign rpt_fire         = 1'b0;
    assign rpt_up           = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        who_d     = who_q;
        shine_d   = shine_q;
        cmd_d     = '0;
        blink_clr = 1'b0;
        blink_en  = 1'b0;
        to_clr    = 1'b0;
        to_en     = 1'b0;
        case (state_q)
            ST_VIEW: begin
                shine_d   = 1'b0;
                blink_clr = 1'b1;
                to_clr    = 1'b1;
                if (key_pulse[KEY_MODE]) begin
                    state_d = ST_EDIT;
                    who_d   = '0;
                    shine_d = 1'b1;
                end
            end
            ST_EDIT: begin
                blink_en = 1'b1;
                to_en    = 1'b1;
                if (blink_tc) begin
                    shine_d = ~shine_q;
                end
                // Dropped lower-priority pulses still count as activity.
                if (any_key || rpt_fire) begin
                    to_clr    = 1'b1;
                    blink_clr = 1'b1;
                    shine_d   = 1'b1;
                end
                if (sel[KEY_MODE]) begin
                    state_d = ST_VIEW;
                    shine_d = 1'b0;
                end else if (sel[KEY_LEFT]) begin
                    who_d       = (who_q == CURSOR_W'(DIGITS - 1)) ? '0 : who_q + CURSOR_W'(1);
                    cmd_d.l_mov = 1'b1;
                end else if (sel[KEY_RIGHT]) begin
                    who_d       = (who_q == '0) ? CURSOR_W'(DIGITS - 1) : who_q - CURSOR_W'(1);
                    cmd_d.r_mov = 1'b1;
                end else if (sel[KEY_UP]) begin
                    cmd_d.add = 1'b1;
                end else if (sel[KEY_DOWN]) begin
                    cmd_d.sub = 1'b1;
                end else if (rpt_fire) begin
                    cmd_d.add = rpt_up;
                    cmd_d.sub = ~rpt_up;
                end else if (to_tc) begin
                    state_d = ST_VIEW;
                    shine_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk100mhz or posedge clr) begin
        if (clr) begin
            state_q <= ST_VIEW;
            who_q   <= '0;
            shine_q <= 1'b0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            who_q   <= who_d;
            shine_q <= shine_d;
            cmd_q   <= cmd_d;
        end
    end

    assign state = state_q;
    assign shine = shine_q;
    assign who   = who_q;
    assign l_mov = cmd_q.l_mov;
    assign r_mov = cmd_q.r_mov;
    assign add   = cmd_q.add;
    assign sub   = cmd_q.sub;

endmodule

// File: tb/tb_edit_sequencer.sv
// Scoreboard bench for edit_sequencer; repeat expectations follow AUTO_REPEAT_EN.
module tb_edit_sequencer;

    localparam int DIGITS     = 8;
    localparam int BLINK_DIV  = 4;
    localparam int TIMEOUT    = 20;
    localparam int RPT_DELAY  = 6;
    localparam int RPT_RATE   = 3;
`ifdef AUTO_REPEAT_EN
    localparam bit RPT = 1'b1;
`else
    localparam bit RPT = 1'b0;
`endif

    localparam logic [4:0] K_NONE  = 5'b00000;
    localparam logic [4:0] K_MODE  = 5'b00001;
    localparam logic [4:0] K_LEFT  = 5'b00010;
    localparam logic [4:0] K_RIGHT = 5'b00100;
    localparam logic [4:0] K_UP    = 5'b01000;
    localparam logic [4:0] K_DOWN  = 5'b10000;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [4:0] key_pulse = '0;
    logic [4:0] key_level = '0;
    logic       state, shine, l_mov, r_mov, add, sub;
    logic [3:0] who;

    int n_checks = 0;
    int n_fail   = 0;
    int n_adds   = 0;

    logic [9:0] exp_q[$];

    // Reference model state
    bit m_edit, m_shine, m_l, m_r, m_a, m_s, m_rpt, m_rpt_up;
    int m_who, m_blink, m_idle, m_cd;

    edit_sequencer #(
        .DIGITS         (DIGITS),
        .BLINK_DIV      (BLINK_DIV),
        .TIMEOUT_CYCLES (TIMEOUT),
        .REPEAT_DELAY   (RPT_DELAY),
        .REPEAT_RATE    (RPT_RATE)
    ) dut (
        .clk100mhz (clk),
        .clr       (clr),
        .key_pulse (key_pulse),
        .key_level (key_level),
        .state     (state),
        .shine     (shine),
        .who       (who),
        .l_mov     (l_mov),
        .r_mov     (r_mov),
        .add       (add),
        .sub       (sub)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] dut_bundle();
        return {state, shine, who, l_mov, r_mov, add, sub};
    endfunction

    function automatic logic [9:0] model_bundle();
        return {m_edit, m_shine, 4'(m_who), m_l, m_r, m_a, m_s};
    endfunction

    task automatic model_reset();
        m_edit = 0; m_shine = 0; m_l = 0; m_r = 0; m_a = 0; m_s = 0;
        m_rpt = 0; m_rpt_up = 0; m_who = 0; m_blink = 0; m_idle = 0; m_cd = 0;
    endtask

    task automatic model_step(input logic [4:0] kp, input logic [4:0] kl);
        bit fire;
        fire = 0;
        m_l = 0; m_r = 0; m_a = 0; m_s = 0;
        if (!m_edit) begin
            m_rpt = 0;
            if (kp[0]) begin
                m_edit = 1; m_who = 0; m_shine = 1; m_blink = 0; m_idle = 0;
            end
        end else if (kp != 0) begin
            m_idle = 0; m_blink = 0; m_shine = 1; m_rpt = 0;
            if (kp[0]) begin
                m_edit = 0; m_shine = 0;
            end else if (kp[1]) begin
                m_who = (m_who + 1) % DIGITS; m_l = 1;
            end else if (kp[2]) begin
                m_who = (m_who + DIGITS - 1) % DIGITS; m_r = 1;
            end else begin
                m_a = kp[3]; m_s = !kp[3];
                m_rpt = 1; m_rpt_up = kp[3]; m_cd = RPT_DELAY;
            end
        end else begin
            if (RPT && m_rpt && (m_rpt_up ? kl[3] : kl[4])) begin
                m_cd--;
                if (m_cd == 0) begin
                    fire = 1; m_cd = RPT_RATE;
                end
            end else begin
                m_rpt = 0;
            end
            if (fire) begin
                m_a = kl[3]; m_s = !kl[3]; m_idle = 0; m_blink = 0; m_shine = 1;
            end else if (m_idle == TIMEOUT - 1) begin
                m_edit = 0; m_shine = 0; m_rpt = 0;
            end else begin
                m_idle++;
                if (m_blink == BLINK_DIV - 1) begin
                    m_blink = 0; m_shine = !m_shine;
                end else begin
                    m_blink++;
                end
            end
        end
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic cycle(input logic [4:0] kp, input logic [4:0] kl);
        key_pulse = kp;
        key_level = kl;
        @(posedge clk);
        model_step(kp, kl);
        exp_q.push_back(model_bundle());
        #1;
        check("cyc", 32'(dut_bundle()), 32'(exp_q.pop_front()));
        key_pulse = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(K_NONE, K_NONE);
    endtask

    initial begin
        model_reset();
        #12;
        check("rst", 32'(dut_bundle()), 32'(0));
        @(posedge clk);
        #1;
        clr = 1'b0;
        idle(2);

        // VIEW ignores everything but mode
        cycle(K_UP, K_NONE);
        cycle(K_DOWN, K_NONE);
        cycle(K_LEFT, K_NONE);
        cycle(K_RIGHT, K_NONE);
        check("view_who", 32'(who), 32'(0));

        cycle(K_MODE, K_NONE);
        for (int i = 0; i < 5; i++) cycle(K_LEFT, K_NONE);
        check("pre_clr_who", 32'({state, who}), 32'({1'b1, 4'd5}));

        // asynchronous clear in the middle of a cycle
        clr = 1'b1;
        #2;
        check("clr_async", 32'(dut_bundle()), 32'(0));
        model_reset();
        @(posedge clk);
        #1;
        check("clr_hold", 32'(dut_bundle()), 32'(0));
        clr = 1'b0;
        idle(3);
        cycle(K_MODE, K_NONE);
        check("reenter", 32'({state, shine, who}), 32'({1'b1, 1'b1, 4'd0}));

        cycle(K_RIGHT, K_NONE);
        check("wrap_r", 32'({r_mov, who}), 32'({1'b1, 4'd7}));
        cycle(K_LEFT, K_NONE);
        check("wrap_l", 32'({l_mov, who}), 32'({1'b1, 4'd0}));
        cycle(K_UP, K_NONE);
        cycle(K_DOWN, K_NONE);
        cycle(K_DOWN | K_UP, K_NONE);
        idle(2);

        cycle(K_MODE | K_LEFT | K_UP, K_NONE);
        check("multi", 32'({state, l_mov, add}), 32'(0));

        // idle blink then timeout
        cycle(K_MODE, K_NONE);
        idle(TIMEOUT - 1);
        check("pre_timeout", 32'(state), 32'(1));
        idle(1);
        check("timeout", 32'({state, shine}), 32'(0));
        idle(2);

        // key in the expiry cycle cancels the timeout
        cycle(K_MODE, K_NONE);
        idle(TIMEOUT - 1);
        cycle(K_UP, K_NONE);
        check("expiry_key", 32'({state, add}), 32'({1'b1, 1'b1}));
        idle(3);

        // held up key
        n_adds = 0;
        cycle(K_UP, K_UP);
        if (add) n_adds++;
        for (int i = 0; i < 14; i++) begin
            cycle(K_NONE, K_UP);
            if (add) n_adds++;
        end
        for (int i = 0; i < 10; i++) begin
            cycle(K_NONE, K_NONE);
            if (add) n_adds++;
        end
        check("rpt_adds", 32'(n_adds), RPT ? 32'(4) : 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
